// File: rtl/fast_down_counter.sv
// fast_down_counter
//   Saturating down-counter with a programmable step. The low STEPW bits are
//   subtracted directly while the upper part is pre-decremented in parallel;
//   the low-half borrow selects between the original and the decremented
//   upper half.
//
// Ports
//   s_clk_i       clock, rising edge
//   s_resetn_i    asynchronous active-low reset
//   s_load_i      load request (highest priority)
//   s_load_val_i  value for the counter and the reload register
//   s_stop_i      halt counting (RUN -> IDLE, count held)
//   s_en_i        decrement enable for this cycle
//   s_step_i      amount subtracted per enabled cycle
//   s_count_o     current count (registered)
//   s_running_o   high while in RUN (registered)
//   s_expired_o   one-cycle pulse after the count reaches zero (registered)
module fast_down_counter #(
  parameter int WIDTH      = 32,
  parameter int STEPW      = 16,
  parameter int AUTORELOAD = 0
) (
  input  logic             s_clk_i,
  input  logic             s_resetn_i,
  input  logic             s_load_i,
  input  logic [WIDTH-1:0] s_load_val_i,
  input  logic             s_stop_i,
  input  logic             s_en_i,
  input  logic [STEPW-1:0] s_step_i,
  output logic [WIDTH-1:0] s_count_o,
  output logic             s_running_o,
  output logic             s_expired_o
);

  localparam int HW = WIDTH - STEPW;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             expired_q, expired_d;

  // Split-borrow subtract: both upper-half candidates exist before the
  // low-half borrow resolves, so the borrow only drives a mux.
  logic [STEPW:0]   lo_diff;
  logic [HW-1:0]    hi_dec;
  logic             lo_borrow;
  logic [WIDTH-1:0] dec_val;
  logic [WIDTH-1:0] step_ext;
  logic             saturate;

  always_comb begin
    lo_diff   = {1'b0, count_q[STEPW-1:0]} - {1'b0, s_step_i};
    lo_borrow = lo_diff[STEPW];
    hi_dec    = count_q[WIDTH-1:STEPW] - HW'(1);
    dec_val   = {(lo_borrow ? hi_dec : count_q[WIDTH-1:STEPW]),
                 lo_diff[STEPW-1:0]};
    step_ext  = {{HW{1'b0}}, s_step_i};
    // Reaching or passing zero: never let the subtract wrap.
    saturate  = (step_ext >= count_q);
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    expired_d = 1'b0;
    if (s_load_i) begin
      count_d  = s_load_val_i;
      reload_d = s_load_val_i;
      if (s_load_val_i == '0) begin
        state_d   = ST_IDLE;
        expired_d = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else if (state_q == ST_RUN) begin
      if (s_stop_i) begin
        state_d = ST_IDLE;
      end else if (s_en_i) begin
        if (saturate) begin
          expired_d = 1'b1;
          if ((AUTORELOAD != 0) && (reload_q != '0)) begin
            count_d = reload_q;
          end else begin
            count_d = '0;
            state_d = ST_IDLE;
          end
        end else begin
          count_d = dec_val;
        end
      end
    end
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      expired_q <= expired_d;
    end
  end

  assign s_count_o   = count_q;
  assign s_running_o = (state_q == ST_RUN);
  assign s_expired_o = expired_q;

endmodule

// File: tb/tb_fast_down_counter.sv
// Testbench for fast_down_counter: two instances (stop-at-zero and
// auto-reload) share stimulus; a behavioural model predicts each cycle and a
// separate monitor compares the registered outputs against the queue.
module tb_fast_down_counter;

  localparam int W  = 32;
  localparam int SW = 16;

  logic          clk;
  logic          rst_n;
  logic          load;
  logic [W-1:0]  load_val;
  logic          stop;
  logic          en;
  logic [SW-1:0] step;

  logic [W-1:0]  count0, count1;
  logic          run0, run1, exp0, exp1;

  fast_down_counter #(.WIDTH(W), .STEPW(SW), .AUTORELOAD(0)) dut0 (
    .s_clk_i(clk), .s_resetn_i(rst_n), .s_load_i(load), .s_load_val_i(load_val),
    .s_stop_i(stop), .s_en_i(en), .s_step_i(step),
    .s_count_o(count0), .s_running_o(run0), .s_expired_o(exp0));

  fast_down_counter #(.WIDTH(W), .STEPW(SW), .AUTORELOAD(1)) dut1 (
    .s_clk_i(clk), .s_resetn_i(rst_n), .s_load_i(load), .s_load_val_i(load_val),
    .s_stop_i(stop), .s_en_i(en), .s_step_i(step),
    .s_count_o(count1), .s_running_o(run1), .s_expired_o(exp1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint unsigned count;
    longint unsigned reload;
    bit              run;
    bit              expired;
  } model_t;

  typedef struct {
    longint unsigned c0;
    bit              r0, e0;
    longint unsigned c1;
    bit              r1, e1;
  } exp_t;

  model_t m[2];
  exp_t   q[$];
  int     n_total = 0;
  int     n_pass  = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
  endtask

  // Counter behaviour in terms of plain arithmetic on the count value.
  function automatic model_t advance(input model_t s, input bit autoreload,
                                     input bit ld, input longint unsigned lv,
                                     input bit st, input bit e, input longint unsigned stp);
    model_t n = s;
    n.expired = 1'b0;
    if (ld) begin
      n.count   = lv;
      n.reload  = lv;
      n.run     = (lv != 0);
      n.expired = (lv == 0);
    end else if (s.run && st) begin
      n.run = 1'b0;
    end else if (s.run && e) begin
      if (stp >= s.count) begin
        n.expired = 1'b1;
        if (autoreload && s.reload != 0) n.count = s.reload;
        else begin
          n.count = 0;
          n.run   = 1'b0;
        end
      end else begin
        n.count = s.count - stp;
      end
    end
    return n;
  endfunction

  function automatic model_t model_reset();
    model_t z;
    z.count = 0; z.reload = 0; z.run = 0; z.expired = 0;
    return z;
  endfunction

  task automatic cycle(input bit ld, input logic [W-1:0] lv, input bit st,
                       input bit e, input logic [SW-1:0] stp);
    exp_t x;
    @(negedge clk);
    load = ld; load_val = lv; stop = st; en = e; step = stp;
    m[0] = advance(m[0], 1'b0, ld, lv, st, e, stp);
    m[1] = advance(m[1], 1'b1, ld, lv, st, e, stp);
    x.c0 = m[0].count; x.r0 = m[0].run; x.e0 = m[0].expired;
    x.c1 = m[1].count; x.r1 = m[1].run; x.e1 = m[1].expired;
    q.push_back(x);
  endtask

  // Monitor: outputs are presented every cycle, so each edge with a pending
  // prediction is compared.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("count0",   count0, x.c0);
        chk("running0", run0,   x.r0);
        chk("expired0", exp0,   x.e0);
        chk("count1",   count1, x.c1);
        chk("running1", run1,   x.r1);
        chk("expired1", exp1,   x.e1);
      end
    end
  end

  initial begin
    logic [W-1:0]  lv;
    logic [SW-1:0] stp;
    int unsigned   sel;

    rst_n = 1'b0; load = 0; load_val = '0; stop = 0; en = 0; step = '0;
    m[0] = model_reset(); m[1] = model_reset();
    #12;
    chk("reset_count0", count0, 0); chk("reset_run0", run0, 0); chk("reset_exp0", exp0, 0);
    chk("reset_count1", count1, 0); chk("reset_run1", run1, 0); chk("reset_exp1", exp1, 0);
    @(negedge clk); rst_n = 1'b1;

    // Countdown 5..0 with step 1, then held in IDLE.
    cycle(1, 32'h5, 0, 1, 16'h1);
    repeat (7) cycle(0, '0, 0, 1, 16'h1);

    // Borrow across the half boundary, then exact hit to zero.
    cycle(1, 32'h0001_0000, 0, 0, 16'h1);
    cycle(0, '0, 0, 1, 16'h0001);
    cycle(0, '0, 0, 1, 16'hFFFF);
    cycle(0, '0, 0, 1, 16'hFFFF);

    // Saturation instead of wrap.
    cycle(1, 32'h10, 0, 0, 16'h0);
    cycle(0, '0, 0, 1, 16'h0100);
    cycle(0, '0, 0, 1, 16'h0100);

    // Auto-reload sequence 3,2,1,3,... on the second instance.
    cycle(1, 32'h3, 0, 1, 16'h1);
    repeat (10) cycle(0, '0, 0, 1, 16'h1);

    // Load of zero, step of zero, en low.
    cycle(1, 32'h0, 0, 1, 16'h1);
    cycle(1, 32'h9, 0, 1, 16'h0);
    cycle(0, '0, 0, 0, 16'h5);

    // Priority: load beats stop and decrement, then stop alone.
    cycle(1, 32'h4, 0, 0, 16'h0);
    cycle(0, '0, 0, 1, 16'h2);
    cycle(1, 32'h20, 1, 1, 16'h2);
    cycle(0, '0, 1, 1, 16'h2);
    cycle(0, '0, 0, 1, 16'h2);

    // Load overrides a same-cycle expiry.
    cycle(1, 32'h2, 0, 0, 16'h0);
    cycle(1, 32'h7, 0, 1, 16'h2);
    cycle(0, '0, 0, 1, 16'h1);

    // Asynchronous reset between edges while counting.
    cycle(1, 32'h1234, 0, 1, 16'h1);
    cycle(0, '0, 0, 1, 16'h1);
    @(negedge clk);
    load = 0; en = 1; step = 16'h1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_count0", count0, 0); chk("async_run0", run0, 0); chk("async_exp0", exp0, 0);
    chk("async_count1", count1, 0); chk("async_run1", run1, 0); chk("async_exp1", exp1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m[0] = model_reset(); m[1] = model_reset();
    repeat (3) cycle(0, '0, 0, 1, 16'h1);

    // Randomized traffic biased toward expiries and half-boundary borrows.
    for (int i = 0; i < 2000; i++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: lv = $urandom();
        1: lv = W'($urandom_range(0, 40));
        2: lv = 32'h0001_0000 + W'($urandom_range(0, 3)) - 32'h2;
        default: lv = {W'($urandom_range(0, 3)), 16'h0} | W'($urandom_range(0, 15));
      endcase
      stp = ($urandom_range(0, 1) == 1) ? SW'($urandom()) : SW'($urandom_range(0, 5));
      cycle($urandom_range(0, 15) == 0, lv, $urandom_range(0, 19) == 0,
            $urandom_range(0, 3) != 0, stp);
    end

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
